// File: rtl/wb_regfile.sv
// Write-back stage and 32-entry architectural register file.
// Selects the write-back value, commits it, bypasses it to the ID read ports and counts retired writes.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [DATA_W-1:0] ReadData_in,
    input  logic [DATA_W-1:0] ALUResult_in,
    input  logic [ADDR_W-1:0] WriteReg_in,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    input  logic [ADDR_W-1:0] ReadReg1_in,
    input  logic [ADDR_W-1:0] ReadReg2_in,
    output logic [DATA_W-1:0] ReadData1_out,
    output logic [DATA_W-1:0] ReadData2_out,
    output logic [DATA_W-1:0] WriteData_out,
    output logic              WriteEn_out,
    output logic [CNT_W-1:0]  RetireCount_out,
    output logic [CNT_W-1:0]  LoadCount_out
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_stall_q;
    logic [CNT_W-1:0]  r_retire_cnt;
    logic [CNT_W-1:0]  r_load_cnt;

    logic [DATA_W-1:0] w_wdata;
    logic              w_wen;
    logic [ADDR_W-1:0] w_raddr [2];
    logic [DATA_W-1:0] w_rdata [2];

    assign w_wdata = MemtoReg_in ? ReadData_in : ALUResult_in;
    assign w_wen   = RegWrite_in && (WriteReg_in != '0);

    assign w_raddr[0] = ReadReg1_in;
    assign w_raddr[1] = ReadReg2_in;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic w_hit;
            assign w_hit = (BYPASS != 0) && w_wen && (w_raddr[gi] == WriteReg_in);
            // r0 is forced to zero explicitly so it never depends on array contents.
            assign w_rdata[gi] = (w_raddr[gi] == '0) ? '0 :
                                 w_hit               ? w_wdata :
                                                       r_mem[w_raddr[gi]];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_stall_q    <= 1'b0;
            r_retire_cnt <= '0;
            r_load_cnt   <= '0;
        end else begin
            r_stall_q <= stall;
            if (w_wen) begin
                r_mem[WriteReg_in] <= w_wdata;
                // A held entry repeats its write but is only counted on its first edge.
                if (!r_stall_q) begin
                    r_retire_cnt <= r_retire_cnt + 1'b1;
                    if (MemtoReg_in) begin
                        r_load_cnt <= r_load_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign ReadData1_out   = w_rdata[0];
    assign ReadData2_out   = w_rdata[1];
    assign WriteData_out   = w_wdata;
    assign WriteEn_out     = w_wen;
    assign RetireCount_out = r_retire_cnt;
    assign LoadCount_out   = r_load_cnt;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: bypass, no-bypass and narrow-counter instances share one stimulus.
// Expected values are queued when stimulus is driven and popped at each check point.
module tb_wb_regfile;
    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] rd_data;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic        rwe;
    logic        m2r;
    logic [4:0]  rr1;
    logic [4:0]  rr2;

    logic [31:0] a_rd1, a_rd2, a_wd, a_rc, a_lc;
    logic        a_we;
    logic [31:0] b_rd1, b_rd2, b_wd, b_rc, b_lc;
    logic        b_we;
    logic [31:0] c_rd1, c_rd2, c_wd;
    logic [3:0]  c_rc, c_lc;
    logic        c_we;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32), .BYPASS(1)) u_a (
        .clk(clk), .reset(reset), .stall(stall),
        .ReadData_in(rd_data), .ALUResult_in(alu), .WriteReg_in(wreg),
        .RegWrite_in(rwe), .MemtoReg_in(m2r),
        .ReadReg1_in(rr1), .ReadReg2_in(rr2),
        .ReadData1_out(a_rd1), .ReadData2_out(a_rd2), .WriteData_out(a_wd),
        .WriteEn_out(a_we), .RetireCount_out(a_rc), .LoadCount_out(a_lc)
    );

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32), .BYPASS(0)) u_b (
        .clk(clk), .reset(reset), .stall(stall),
        .ReadData_in(rd_data), .ALUResult_in(alu), .WriteReg_in(wreg),
        .RegWrite_in(rwe), .MemtoReg_in(m2r),
        .ReadReg1_in(rr1), .ReadReg2_in(rr2),
        .ReadData1_out(b_rd1), .ReadData2_out(b_rd2), .WriteData_out(b_wd),
        .WriteEn_out(b_we), .RetireCount_out(b_rc), .LoadCount_out(b_lc)
    );

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4), .BYPASS(1)) u_c (
        .clk(clk), .reset(reset), .stall(stall),
        .ReadData_in(rd_data), .ALUResult_in(alu), .WriteReg_in(wreg),
        .RegWrite_in(rwe), .MemtoReg_in(m2r),
        .ReadReg1_in(rr1), .ReadReg2_in(rr2),
        .ReadData1_out(c_rd1), .ReadData2_out(c_rd2), .WriteData_out(c_wd),
        .WriteEn_out(c_we), .RetireCount_out(c_rc), .LoadCount_out(c_lc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [31:0] v);
        sb.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %h but scoreboard empty", tag, obs);
        end else begin
            exp = sb.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rwe = 1'b0; m2r = 1'b0; stall = 1'b0;
        wreg = 5'd0; alu = 32'd0; rd_data = 32'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        reset = 1'b1; rr1 = 5'd0; rr2 = 5'd0;
        idle();
        #3;
        push(32'd0); chk("reset_wd", a_wd);
        do_reset();

        // 1: all registers read zero after reset
        for (int i = 1; i < 32; i++) begin
            rr1 = 5'(i); rr2 = 5'(i);
            #1;
            push(32'd0); chk($sformatf("rst_r%0d_p1", i), a_rd1);
            push(32'd0); chk($sformatf("rst_r%0d_p2", i), b_rd2);
        end
        push(32'd0); chk("rst_rc", a_rc);
        push(32'd0); chk("rst_lc", a_lc);

        rwe = 1'b1; wreg = 5'd5; alu = 32'hDEADBEEF; rr1 = 5'd5;
        push(32'hDEADBEEF);
        tick();
        idle();
        #1;
        chk("r5_written", a_rd1);
        push(32'd1); chk("r5_rc", a_rc);
        #2;
        reset = 1'b1;
        #1;
        push(32'd0); chk("async_rst_r5", a_rd1);
        push(32'd0); chk("async_rst_rc", a_rc);
        push(32'd0); chk("async_rst_lc", a_lc);
        tick();
        reset = 1'b0;

        // 2: same-cycle bypass vs. registered visibility
        rwe = 1'b1; wreg = 5'd8; m2r = 1'b0; alu = 32'h12345678; rr1 = 5'd8;
        #1;
        push(32'h12345678); chk("byp_same_cycle", a_rd1);
        push(32'd0);        chk("nobyp_same_cycle", b_rd1);
        push(32'd1);        chk("byp_we", {31'd0, a_we});
        tick();
        idle();
        #1;
        push(32'h12345678); chk("byp_persist", a_rd1);
        push(32'h12345678); chk("nobyp_next_cycle", b_rd1);
        push(32'd1);        chk("w8_rc", a_rc);

        // 3: writes to r0 are suppressed
        rwe = 1'b1; wreg = 5'd0; alu = 32'hFFFFFFFF; rr1 = 5'd0; rr2 = 5'd0;
        #1;
        push(32'd0);        chk("r0_we", {31'd0, a_we});
        push(32'hFFFFFFFF); chk("r0_wd", a_wd);
        push(32'd0);        chk("r0_p1", a_rd1);
        push(32'd0);        chk("r0_p2", a_rd2);
        tick();
        idle();
        #1;
        push(32'd1); chk("r0_rc_unchanged", a_rc);
        push(32'd0); chk("r0_p1_after", a_rd1);
        push(32'd0); chk("r0_nobyp_after", b_rd2);

        // 4: stalled load entry is written but counted once
        rwe = 1'b1; m2r = 1'b1; rd_data = 32'hA5A5A5A5; alu = 32'h11111111;
        wreg = 5'd3; stall = 1'b1; rr1 = 5'd3;
        #1;
        push(32'hA5A5A5A5); chk("load_wd", a_wd);
        push(32'hA5A5A5A5); chk("load_bypass", a_rd1);
        tick();
        tick();
        tick();
        stall = 1'b0;
        tick();
        idle();
        #1;
        push(32'hA5A5A5A5); chk("load_r3", a_rd1);
        push(32'hA5A5A5A5); chk("load_r3_nobyp", b_rd1);
        push(32'd2);        chk("load_rc", a_rc);
        push(32'd1);        chk("load_lc", a_lc);

        // 5: 17 writes on a 4-bit counter wrap to 1
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            v = 32'h10000000 + (32'(i) * 32'h01010101);
            rwe = 1'b1; wreg = 5'(i); alu = v;
            push(v);
            tick();
            $display("write r%0d <= %h", i, v);
        end
        idle();
        for (int i = 1; i <= 17; i++) begin
            rr1 = 5'(i);
            #1;
            chk($sformatf("wrap_r%0d", i), c_rd1);
        end
        push(32'd1);  chk("wrap_rc4", {28'd0, c_rc});
        push(32'd17); chk("wrap_rc32", a_rc);

        // 6: flush bubble on both ports
        v = 32'h10000000 + (32'd9 * 32'h01010101);
        rwe = 1'b0; wreg = 5'd9; alu = 32'h00000BAD; rr1 = 5'd9; rr2 = 5'd9;
        #1;
        push(v);    chk("bubble_p1", a_rd1);
        push(v);    chk("bubble_p2", a_rd2);
        push(32'd0); chk("bubble_we", {31'd0, a_we});
        tick();
        #1;
        push(v);     chk("bubble_p1_after", a_rd1);
        push(v);     chk("bubble_p2_nobyp", b_rd2);
        push(32'd17); chk("bubble_rc", a_rc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline interface: the write-back stage plus the architectural register file.
- Selects the write-back value (memory data or ALU result) from the MEM/WB outputs and commits it to a 32-entry register file.
- Serves the two ID-stage read ports with same-cycle write-through bypass.
- Keeps retired-write and retired-load counters; stall-repeated entries are counted once.

Parameters:
DATA_W, 32, register and data width
ADDR_W, 5, register address width (2**ADDR_W entries)
CNT_W, 32, width of the retire counters
BYPASS, 1, 1 = read ports see the same-cycle write value; 0 = read ports return stored array contents only

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears array, counters and internal state
stall  in  1  same stall that drives MEM/WB; 1 = MEM/WB outputs this cycle repeat next cycle
ReadData_in  in  DATA_W  memory load data from MEM/WB
ALUResult_in  in  DATA_W  ALU result from MEM/WB
WriteReg_in  in  ADDR_W  destination register from MEM/WB
RegWrite_in  in  1  write enable from MEM/WB
MemtoReg_in  in  1  1 = select ReadData_in, 0 = select ALUResult_in
ReadReg1_in  in  ADDR_W  rs address from ID
ReadReg2_in  in  ADDR_W  rt address from ID
ReadData1_out  out  DATA_W  rs value
ReadData2_out  out  DATA_W  rt value
WriteData_out  out  DATA_W  selected write-back value, fed to the forwarding muxes
WriteEn_out  out  1  effective write enable: RegWrite_in && WriteReg_in != 0
RetireCount_out  out  CNT_W  count of committed register writes
LoadCount_out  out  CNT_W  count of committed writes with MemtoReg_in = 1

Behaviour:
- Reset is asynchronous and active-high. It clears all array entries, both counters and stall_q to 0 immediately.
- Reset asserted mid-operation overrides everything. The first posedge after deassertion behaves as a fresh entry.
- WriteData_out = MemtoReg_in ? ReadData_in : ALUResult_in. Purely combinational; it equals ALUResult_in (0 from a reset bubble) while reset is held.
- WriteEn_out is combinational. Writes to register 0 are always suppressed.
- Array write: at posedge when WriteEn_out = 1, mem[WriteReg_in] <= WriteData_out. Single-cycle latency.
  - A write is repeated while stall is held. This is idempotent and permitted.
- Register 0 always reads 0, on both ports and with either BYPASS setting.
- Reads are combinational.
  - BYPASS = 1: if ReadRegN_in == WriteReg_in, WriteEn_out = 1 and ReadRegN_in != 0, then ReadDataN_out = WriteData_out. Otherwise ReadDataN_out = mem[ReadRegN_in].
  - BYPASS = 0: ReadDataN_out = mem[ReadRegN_in]; the new value is visible from the cycle after the write edge.
  - Both ports are independent. The same address on both ports returns the same value.
- New-entry tracking: stall_q <= stall at every posedge (reset value 0). The entry is new when stall_q == 0.
- Counters:
  - At posedge with WriteEn_out = 1 and stall_q = 0: RetireCount_out increments by 1.
  - Same condition plus MemtoReg_in = 1: LoadCount_out also increments by 1.
  - Both counters wrap modulo 2**CNT_W; no saturation.
  - A stall of any length counts the held entry once.
- Flush bubbles arrive with RegWrite_in = 0: no write, no count.
- Simultaneous stall and write on the same edge: the write occurs; the count follows stall_q, not the current stall.

Test Plan:
1. Reset, then read r1..r31 -> all reads 0. Assert reset mid-run after writing r5 = 0xDEADBEEF -> r5 reads 0 at once; both counters 0.
2. RegWrite = 1, WriteReg = 8, MemtoReg = 0, ALUResult = 0x12345678, ReadReg1 = 8, BYPASS = 1 -> ReadData1 = 0x12345678 in the same cycle; stored value persists after RegWrite drops. With BYPASS = 0 -> old value (0) that cycle, 0x12345678 the next cycle.
3. WriteReg = 0, RegWrite = 1, ALUResult = 0xFFFFFFFF -> WriteEn_out = 0; r0 reads 0 on both ports; RetireCount unchanged.
4. Load entry (MemtoReg = 1, ReadData = 0xA5A5A5A5, WriteReg = 3) held with stall = 1 for 3 cycles, then stall = 0 -> r3 = 0xA5A5A5A5; RetireCount +1 and LoadCount +1 total, not +4.
5. CNT_W = 4, 17 back-to-back unstalled writes to r1..r17 with distinct values -> RetireCount = 1 (wrapped); all 17 registers hold their values.
6. Both ports on r9 while a flush bubble (RegWrite = 0) is presented -> both ports return the stored r9 value; no write, no count.
